// File: rtl/qpu_imem_arb_pkg.sv
// Shared constants for the QPU instruction-memory arbiter: requester IDs and
// default sizing used by qpu_imem_arbiter and its ID FIFO.
package qpu_imem_arb_pkg;

    localparam logic ARB_ID_IFU  = 1'b0;
    localparam logic ARB_ID_HOST = 1'b1;

    localparam int unsigned DEF_OUTS_DEPTH = 2;
    localparam int unsigned DEF_STARVE_LIM = 8;

endpackage

// File: rtl/qpu_imem_arb_idfifo.sv
// In-order FIFO of 1-bit requester IDs, one entry per outstanding memory
// command; head names the requester owning the next memory response.
module qpu_imem_arb_idfifo
    import qpu_imem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_OUTS_DEPTH,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          push_id,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          head
);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = ids[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) ids[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/qpu_imem_arbiter.sv
// Shares the ITCM command/response port between the IFU fetch channel and the
// host loader. Define QPU_IMEM_ARB_RR_EN for round-robin instead of host
// priority with IFU starvation override.
module qpu_imem_arbiter
    import qpu_imem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned OUTS_DEPTH = DEF_OUTS_DEPTH,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM,
    localparam int unsigned CW        = $clog2(OUTS_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_pc,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_instr,
    input  logic          host_req_valid,
    output logic          host_req_ready,
    input  logic [AW-1:0] host_req_addr,
    input  logic          host_req_write,
    input  logic [DW-1:0] host_req_wdata,
    output logic          host_rsp_valid,
    input  logic          host_rsp_ready,
    output logic [DW-1:0] host_rsp_rdata,
    output logic          mem_cmd_valid,
    input  logic          mem_cmd_ready,
    output logic [AW-1:0] mem_cmd_addr,
    output logic          mem_cmd_write,
    output logic [DW-1:0] mem_cmd_wdata,
    input  logic          mem_rsp_valid,
    output logic          mem_rsp_ready,
    input  logic [DW-1:0] mem_rsp_rdata,
    output logic [CW-1:0] outs_cnt,
    output logic          arb_err
);

    logic fifo_full;
    logic fifo_empty;
    logic head_id;
    logic grant_host;
    logic cmd_ok;
    logic cmd_hs;
    logic rsp_pop;

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens the command path and mem_rsp has no route to mem_cmd.
    assign cmd_ok = ~rst & ~fifo_full;
    assign cmd_hs = mem_cmd_valid & mem_cmd_ready;

`ifdef QPU_IMEM_ARB_RR_EN
    logic rr_ptr;

    assign grant_host = host_req_valid & (~ifu_req_valid | (rr_ptr == ARB_ID_HOST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= ARB_ID_IFU;
        else if (cmd_hs) rr_ptr <= ~grant_host;
    end
`else
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    logic          ifu_hs;

    assign starve_hit = (starve_cnt == SW'(STARVE_LIM));
    assign grant_host = host_req_valid & ~(ifu_req_valid & starve_hit);
    assign ifu_hs     = cmd_hs & ~grant_host;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          starve_cnt <= '0;
        else if (ifu_hs | ~ifu_req_valid) starve_cnt <= '0;
        else if (!starve_hit)             starve_cnt <= starve_cnt + SW'(1);
    end
`endif

    always_comb begin
        mem_cmd_valid  = (ifu_req_valid | host_req_valid) & cmd_ok;
        mem_cmd_addr   = grant_host ? host_req_addr : ifu_req_pc;
        mem_cmd_write  = grant_host & host_req_write;
        mem_cmd_wdata  = grant_host ? host_req_wdata : '0;
        host_req_ready = grant_host & mem_cmd_ready & cmd_ok;
        ifu_req_ready  = ~grant_host & mem_cmd_ready & cmd_ok;
    end

    // An empty FIFO still accepts the response so a stray beat cannot wedge memory.
    always_comb begin
        ifu_rsp_valid  = ~rst & ~fifo_empty & (head_id == ARB_ID_IFU) & mem_rsp_valid;
        host_rsp_valid = ~rst & ~fifo_empty & (head_id == ARB_ID_HOST) & mem_rsp_valid;
        mem_rsp_ready  = ~rst & (fifo_empty | ((head_id == ARB_ID_HOST) ? host_rsp_ready
                                                                        : ifu_rsp_ready));
        ifu_rsp_instr  = mem_rsp_rdata;
        host_rsp_rdata = mem_rsp_rdata;
        rsp_pop        = mem_rsp_valid & mem_rsp_ready & ~fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             arb_err <= 1'b0;
        else if (mem_rsp_valid & fifo_empty) arb_err <= 1'b1;
    end

    qpu_imem_arb_idfifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_idfifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_hs),
        .push_id (grant_host),
        .pop     (rsp_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outs_cnt),
        .head    (head_id)
    );

endmodule

// File: tb/tb_qpu_imem_arbiter.sv
// Randomized bench for qpu_imem_arbiter against a transaction-level model of
// grants, outstanding IDs and memory contents, plus directed scenarios.
module tb_qpu_imem_arbiter;
    import qpu_imem_arb_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIM   = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk, rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0] ifu_req_pc;
    logic [DW-1:0] ifu_rsp_instr;
    logic          host_req_valid, host_req_ready, host_req_write;
    logic          host_rsp_valid, host_rsp_ready;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_wdata, host_rsp_rdata;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_rdata;
    logic [CW-1:0] outs_cnt;
    logic          arb_err;

    qpu_imem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .OUTS_DEPTH (DEPTH),
        .STARVE_LIM (LIM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_instr  (ifu_rsp_instr),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_addr  (host_req_addr),
        .host_req_write (host_req_write),
        .host_req_wdata (host_req_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_ready (host_rsp_ready),
        .host_rsp_rdata (host_rsp_rdata),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_cmd_write  (mem_cmd_write),
        .mem_cmd_wdata  (mem_cmd_wdata),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_ready  (mem_rsp_ready),
        .mem_rsp_rdata  (mem_rsp_rdata),
        .outs_cnt       (outs_cnt),
        .arb_err        (arb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { bit dest; bit wr; logic [31:0] data; } ent_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } req_t;

    int unsigned n_vec, n_err;

    // Reference model: expected outstanding responses, memory image, arbitration state
    ent_t        exp_q[$];
    logic [31:0] ref_mem[32];
    int          starve;
    bit          rr_pref;
    bit          m_err;

    // Memory stub driven from observed DUT commands
    logic [31:0] stub_mem[32];
    logic [31:0] mq[$];

    req_t        ifu_list[$], host_list[$];
    bit          ifu_pend, host_pend;
    bit          auto_req, always_req, rdy_rand, spur, rsp_once, log_grants;
    int          rsp_mode;
    bit          grants[$];
    int          n_ifu_rsp, n_host_rsp, max_outs;
    logic [31:0] last_ifu;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic drive();
        req_t r;
        if (!ifu_pend) begin
            if (ifu_list.size() > 0) begin
                r = ifu_list.pop_front();
                ifu_req_valid = 1'b1; ifu_req_pc = r.addr; ifu_pend = 1'b1;
            end else if (auto_req && (always_req || $urandom_range(0, 2) != 0)) begin
                ifu_req_valid = 1'b1; ifu_req_pc = rand_addr(); ifu_pend = 1'b1;
            end else begin
                ifu_req_valid = 1'b0;
            end
        end
        if (!host_pend) begin
            if (host_list.size() > 0) begin
                r = host_list.pop_front();
                host_req_valid = 1'b1; host_req_write = r.wr;
                host_req_addr = r.addr; host_req_wdata = r.data; host_pend = 1'b1;
            end else if (auto_req && (always_req || $urandom_range(0, 2) != 0)) begin
                host_req_valid = 1'b1; host_req_write = 1'($urandom_range(0, 1));
                host_req_addr = rand_addr(); host_req_wdata = $urandom; host_pend = 1'b1;
            end else begin
                host_req_valid = 1'b0; host_req_write = 1'b0;
            end
        end
        mem_cmd_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        ifu_rsp_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        host_rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (spur) begin
            mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
        end else if (mq.size() > 0 &&
                     (rsp_mode == 1 || rsp_once || (rsp_mode == 0 && $urandom_range(0, 2) != 0))) begin
            mem_rsp_valid = 1'b1; mem_rsp_rdata = mq[0]; rsp_once = 1'b0;
        end else begin
            mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
        end
    endtask

    task automatic evaluate();
        bit full, g, exp_cmd, cmd_hs, sel_rdy;
        ent_t e;
        logic [31:0] a;
        full    = (exp_q.size() == DEPTH);
        exp_cmd = (ifu_req_valid || host_req_valid) && !full;
`ifdef QPU_IMEM_ARB_RR_EN
        g = host_req_valid && (!ifu_req_valid || rr_pref);
`else
        g = host_req_valid && !(ifu_req_valid && starve == LIM);
`endif
        check("outs_cnt", outs_cnt, exp_q.size());
        check("arb_err", arb_err, m_err);
        check("cmd_valid", mem_cmd_valid, exp_cmd);
        if (ifu_req_valid)  check("ifu_req_ready", ifu_req_ready, !g && mem_cmd_ready && !full);
        if (host_req_valid) check("host_req_ready", host_req_ready, g && mem_cmd_ready && !full);
        if (exp_cmd) begin
            check("cmd_addr", mem_cmd_addr, g ? host_req_addr : ifu_req_pc);
            check("cmd_write", mem_cmd_write, g && host_req_write);
            check("cmd_wdata", mem_cmd_wdata, g ? host_req_wdata : 32'd0);
        end

        if (exp_q.size() == 0) begin
            check("rsp_ready_empty", mem_rsp_ready, 1);
            check("ifu_rsp_valid", ifu_rsp_valid, 0);
            check("host_rsp_valid", host_rsp_valid, 0);
            if (mem_rsp_valid) m_err = 1'b1;
        end else begin
            e = exp_q[0];
            sel_rdy = e.dest ? host_rsp_ready : ifu_rsp_ready;
            check("ifu_rsp_valid", ifu_rsp_valid, !e.dest && mem_rsp_valid);
            check("host_rsp_valid", host_rsp_valid, e.dest && mem_rsp_valid);
            check("mem_rsp_ready", mem_rsp_ready, sel_rdy);
            if (mem_rsp_valid && sel_rdy) begin
                if (!e.wr) check(e.dest ? "host_rdata" : "ifu_instr",
                                 e.dest ? host_rsp_rdata : ifu_rsp_instr, e.data);
                void'(exp_q.pop_front());
            end
        end

        cmd_hs = exp_cmd && mem_cmd_ready;
        if (cmd_hs) begin
            a      = g ? host_req_addr : ifu_req_pc;
            e.dest = g;
            e.wr   = g && host_req_write;
            e.data = ref_mem[a[6:2]];
            if (e.wr) ref_mem[a[6:2]] = host_req_wdata;
            exp_q.push_back(e);
            rr_pref = !g;
        end
        if (ifu_req_valid && !(cmd_hs && !g)) starve = (starve < LIM) ? starve + 1 : LIM;
        else                                  starve = 0;

        if (mem_rsp_valid && mem_rsp_ready && mq.size() > 0 && !spur) void'(mq.pop_front());
        if (mem_cmd_valid && mem_cmd_ready) begin
            mq.push_back(stub_mem[mem_cmd_addr[6:2]]);
            if (mem_cmd_write) stub_mem[mem_cmd_addr[6:2]] = mem_cmd_wdata;
            if (log_grants) grants.push_back(host_req_valid && host_req_ready);
        end
        if (ifu_req_valid && ifu_req_ready)   ifu_pend = 1'b0;
        if (host_req_valid && host_req_ready) host_pend = 1'b0;
        if (ifu_rsp_valid && ifu_rsp_ready) begin n_ifu_rsp++; last_ifu = ifu_rsp_instr; end
        if (host_rsp_valid && host_rsp_ready) n_host_rsp++;
        if (int'(outs_cnt) > max_outs) max_outs = int'(outs_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1 drive();
        #3 evaluate();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete(); mq.delete(); ifu_list.delete(); host_list.delete();
        starve = 0; rr_pref = ARB_ID_IFU; m_err = 1'b0;
        ifu_pend = 1'b0; host_pend = 1'b0;
        for (int i = 0; i < 32; i++) stub_mem[i] = ref_mem[i];
        @(posedge clk);
        #1;
        ifu_req_valid = 1'b1; host_req_valid = 1'b1; mem_rsp_valid = 1'b1;
        mem_cmd_ready = 1'b1; ifu_rsp_ready = 1'b1; host_rsp_ready = 1'b1;
        #2;
        check("rst_cmd_valid", mem_cmd_valid, 0);
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_host_ready", host_req_ready, 0);
        check("rst_ifu_rsp", ifu_rsp_valid, 0);
        check("rst_host_rsp", host_rsp_valid, 0);
        check("rst_mem_rsp_ready", mem_rsp_ready, 0);
        check("rst_outs_cnt", outs_cnt, 0);
        check("rst_arb_err", arb_err, 0);
        ifu_req_valid = 1'b0; host_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        auto_req = 1'b0; rsp_mode = 1; rdy_rand = 1'b0;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || mq.size() != 0 || ifu_pend || host_pend); i++)
            step();
        check("drain", exp_q.size() + mq.size() + ifu_pend + host_pend, 0);
    endtask

    initial begin
        req_t r;
        bit   start_pref;
        n_vec = 0; n_err = 0;
        auto_req = 0; always_req = 0; rdy_rand = 0; spur = 0; rsp_once = 0; log_grants = 0;
        rsp_mode = 1;
        ifu_req_valid = 0; ifu_req_pc = '0; host_req_valid = 0; host_req_addr = '0;
        host_req_write = 0; host_req_wdata = '0; mem_cmd_ready = 0; mem_rsp_valid = 0;
        mem_rsp_rdata = '0; ifu_rsp_ready = 0; host_rsp_ready = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
        do_reset();

        // IFU-only fetches of 0x0, 0x4, 0x8 with a one-cycle memory
        n_ifu_rsp = 0; n_host_rsp = 0; max_outs = 0;
        for (int i = 0; i < 3; i++) begin
            r.wr = 0; r.addr = 32'(i * 4); r.data = '0; ifu_list.push_back(r);
        end
        for (int i = 0; i < 40 && n_ifu_rsp < 3; i++) step();
        check("ifu_only_rsps", n_ifu_rsp, 3);
        check("ifu_only_max_outs", max_outs <= 1, 1);
        check("ifu_only_host_rsps", n_host_rsp, 0);
        drain();

        // Both requesters valid every cycle
        grants.delete(); start_pref = rr_pref;
        auto_req = 1; always_req = 1; log_grants = 1;
        repeat (32) step();
        log_grants = 0;
        check("grant_count", grants.size() >= 27, 1);
        for (int i = 0; i < 27 && i < grants.size(); i++) begin
`ifdef QPU_IMEM_ARB_RR_EN
            check("rr_grant_seq", grants[i], start_pref ^ 1'(i % 2));
`else
            check("starve_grant_seq", grants[i], (i % 9 == 8) ? 1'b0 : 1'b1);
`endif
        end
        drain();

        // Memory withholds responses until the ID FIFO fills
        auto_req = 1; always_req = 1; rsp_mode = 2;
        repeat (6) step();
        check("full_outs_cnt", outs_cnt, DEPTH);
        check("full_cmd_valid", mem_cmd_valid, 0);
        check("full_ifu_ready", ifu_req_ready, 0);
        check("full_host_ready", host_req_ready, 0);
        rsp_once = 1;
        step();
        step();
        check("release_cmd_valid", mem_cmd_valid, 1);
        check("release_outs_cnt", outs_cnt, DEPTH - 1);
        always_req = 0;
        drain();

        // Host write then IFU fetch of the same word
        n_ifu_rsp = 0; n_host_rsp = 0;
        r.wr = 1; r.addr = 32'h40; r.data = 32'hDEADBEEF; host_list.push_back(r);
        for (int i = 0; i < 40 && n_host_rsp < 1; i++) step();
        r.wr = 0; r.addr = 32'h40; r.data = '0; ifu_list.push_back(r);
        for (int i = 0; i < 40 && n_ifu_rsp < 1; i++) step();
        repeat (3) step();
        check("wr_host_rsps", n_host_rsp, 1);
        check("wr_ifu_rsps", n_ifu_rsp, 1);
        check("wr_ifu_data", last_ifu, 32'hDEADBEEF);
        drain();

        // Random traffic with random backpressure
        auto_req = 1; always_req = 0; rdy_rand = 1; rsp_mode = 0;
        repeat (3000) step();
        drain();

        // Spurious response with nothing outstanding
        spur = 1;
        step();
        spur = 0;
        step();
        check("spur_err_set", arb_err, 1);
        repeat (4) step();
        check("spur_err_hold", arb_err, 1);
        do_reset();
        step();
        check("spur_err_clear", arb_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qpu_imem_arbiter.md
Name: qpu_imem_arbiter

Overview:
- Shares the single instruction-memory command/response port between two requesters: the IFU fetch channel and the host program loader (read/write).
- Tracks outstanding commands in an in-order ID FIFO so each response returns to the requester that issued it.
- Sits between qpu_ifu_ifetch and the ITCM controller.

Parameters:
- AW, 32, address width (equals QPU_PC_SIZE).
- DW, 32, data width (equals QPU_INSTR_SIZE).
- OUTS_DEPTH, 2, maximum outstanding memory commands; power of 2, at least 1.
- STARVE_LIM, 8, number of consecutive cycles the IFU may be denied before it takes priority; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted
- ifu_req_pc  in  AW  fetch address
- ifu_rsp_valid  out  1  IFU response valid
- ifu_rsp_ready  in  1  IFU response ready
- ifu_rsp_instr  out  DW  fetched instruction
- host_req_valid  in  1  loader request
- host_req_ready  out  1  loader request accepted
- host_req_addr  in  AW  loader address
- host_req_write  in  1  1 = write, 0 = read
- host_req_wdata  in  DW  write data
- host_rsp_valid  out  1  loader response valid
- host_rsp_ready  in  1  loader response ready
- host_rsp_rdata  out  DW  read data; undefined for writes
- mem_cmd_valid  out  1  memory command valid
- mem_cmd_ready  in  1  memory command ready
- mem_cmd_addr  out  AW  memory command address
- mem_cmd_write  out  1  memory write enable
- mem_cmd_wdata  out  DW  memory write data
- mem_rsp_valid  in  1  memory response valid; one response per command, in order, writes included
- mem_rsp_ready  out  1  memory response ready
- mem_rsp_rdata  in  DW  memory read data
- outs_cnt  out  $clog2(OUTS_DEPTH+1)  number of outstanding commands
- arb_err  out  1  sticky error: response received with no command outstanding

Behaviour:
- Reset: ID FIFO empty, outs_cnt=0, starvation counter=0, arb_err=0, RR pointer=IFU. All valid/ready outputs are 0 while rst is high.
- fifo_full = (outs_cnt==OUTS_DEPTH).
- Grant is combinational over the two valids:
  - Host has fixed priority.
  - IFU wins when the host is idle, or when starve_cnt==STARVE_LIM.
- mem_cmd_valid = (ifu_req_valid | host_req_valid) & ~fifo_full.
- mem_cmd_* is muxed from the granted requester. IFU commands force write=0 and wdata=0.
- Granted requester's req_ready = mem_cmd_ready & ~fifo_full; the loser's req_ready=0.
- On command handshake, push the requester ID (0=IFU, 1=host) into the FIFO.
- A command is never issued while full, even if a response pops in the same cycle. This avoids a combinational path from mem_rsp to mem_cmd.
- Response routing: head ID selects the destination.
  - That destination's rsp_valid = mem_rsp_valid; the other's is 0.
  - mem_rsp_ready = selected rsp_ready.
  - Response data passes through combinationally; latency is zero cycles.
  - Pop on response handshake.
- Simultaneous push and pop: outs_cnt unchanged; FIFO pointers both advance, wrapping modulo OUTS_DEPTH.
- Response with FIFO empty:
  - mem_rsp_ready=1 and the response is dropped.
  - Neither rsp_valid asserts.
  - arb_err is set and holds until reset.
- Starvation counter, width $clog2(STARVE_LIM+1):
  - Increments each cycle ifu_req_valid=1 and no IFU handshake occurs, saturating at STARVE_LIM.
  - Clears on IFU command handshake, or when ifu_req_valid=0.
- Requesters must hold req fields stable while valid and not ready. The arbiter registers nothing on the command path.
- Asserting rst mid-transfer discards outstanding IDs; the memory controller is reset on the same rst.

Optional Feature:
- Macro: QPU_IMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration replaces fixed priority.
  - A 1-bit pointer names the preferred requester; it flips to the other requester after each command handshake.
  - Starvation counter logic is removed.
- Undefined: host priority plus the STARVE_LIM mechanism as described under Behaviour.
- Ports are identical in both builds.

Decomposition:
- Shared package qpu_imem_arb_pkg:
  - Requester ID constants ARB_ID_IFU=1'b0 and ARB_ID_HOST=1'b1.
  - Default localparams for OUTS_DEPTH and STARVE_LIM.
- One sub-module: qpu_imem_arb_idfifo, a 1-bit-wide, OUTS_DEPTH-deep synchronous FIFO exposing full, empty, count, and head.
- Arbitration and routing stay in the top module.

Test Plan:
- IFU only, mem_cmd_ready=1, 1-cycle memory, PCs 0x0,0x4,0x8 -> three IFU responses in order with matching instrs; outs_cnt never exceeds 1; host_rsp_valid stays 0.
- Both valid every cycle, OUTS_DEPTH=2, STARVE_LIM=8 -> host wins 8 grants; IFU wins the 9th; starve_cnt returns to 0; pattern repeats.
- Memory withholds responses -> after 2 handshakes mem_cmd_valid=0, both req_ready=0, outs_cnt=2; releasing one response re-enables commands the next cycle.
- Host write 0xDEADBEEF to 0x40, then IFU fetch of 0x40 -> host_rsp_valid pulses once; IFU receives 0xDEADBEEF.
- Spurious mem_rsp_valid with outs_cnt=0 -> arb_err=1 next cycle and stays 1; no rsp_valid asserts; assert rst -> arb_err=0.
- QPU_IMEM_ARB_RR_EN defined, both requesters valid continuously -> grants alternate IFU, host, IFU, host.
